// File: rtl/mux_seq_n_1_pkg.sv
// Shared definitions for the N:1 scan selector: FSM state encoding and
// the wrap-around index step used by the scan pointer.
package mux_seq_n_1_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Next index in a ring of num entries; NUM need not be a power of two.
  function automatic int unsigned next_index(input int unsigned idx, input int unsigned num);
    return (idx >= num - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_seq_n_1_if.sv
// Request/response bundle between the fetch logic (master) and the
// N:1 scan selector (slave).
interface mux_seq_n_1_if #(
  parameter int WIDTH = 11,
  parameter int NUM   = 16
);
  localparam int SEL_W = $clog2(NUM);

  logic [NUM*WIDTH-1:0] INS;
  logic [SEL_W-1:0]     sel_in;
  logic [SEL_W-1:0]     last_in;
  logic                 rd;
  logic                 start;
  logic                 adv;
  logic                 abort;
  logic [WIDTH-1:0]     RES;
  logic [SEL_W-1:0]     cur_sel;
  logic                 valid;
  logic                 done;
  logic                 err;

  modport master (
    output INS, sel_in, last_in, rd, start, adv, abort,
    input  RES, cur_sel, valid, done, err
  );

  modport slave (
    input  INS, sel_in, last_in, rd, start, adv, abort,
    output RES, cur_sel, valid, done, err
  );

endinterface

// File: rtl/mux_seq_n_1_mux.sv
// Purely combinational N:1 word mux over a flattened input vector;
// an index past the last word selects zero.
module mux_n_1 #(
  parameter int WIDTH = 11,
  parameter int NUM   = 16
) (
  input  logic [NUM*WIDTH-1:0]     ins,
  input  logic [$clog2(NUM)-1:0]   idx,
  output logic [WIDTH-1:0]         word
);

  localparam int SEL_W = $clog2(NUM);

  always_comb begin
    word = '0;
    for (int k = 0; k < NUM; k++) begin
      if (idx == SEL_W'(k)) begin
        word = ins[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_seq_n_1.sv
// Registered N:1 word selector with a wrap-around scan sequencer:
// direct reads in IDLE, one word per advance in SCAN.
module mux_seq_n_1
  import mux_seq_n_1_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int NUM   = 16
) (
  input logic          clk,
  input logic          rst,
  mux_seq_n_1_if.slave bus
);

  localparam int SEL_W = $clog2(NUM);
  localparam logic [SEL_W:0] NUM_C = (SEL_W+1)'(NUM);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] mux_idx;
  logic [WIDTH-1:0] mux_word;
  logic [WIDTH-1:0] res_q;
  logic [SEL_W-1:0] cur_q;
  logic             valid_q;
  logic             done_q;
  logic             err_q;
  logic             sel_ok;
  logic             last_ok;

  // One extra bit so indices at or above a non-power-of-two NUM are caught.
  assign sel_ok  = {1'b0, bus.sel_in}  < NUM_C;
  assign last_ok = {1'b0, bus.last_in} < NUM_C;

  assign mux_idx = (state == SCAN) ? ptr : bus.sel_in;

  mux_n_1 #(
    .WIDTH (WIDTH),
    .NUM   (NUM)
  ) u_mux (
    .ins  (bus.INS),
    .idx  (mux_idx),
    .word (mux_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      last    <= '0;
      res_q   <= '0;
      cur_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (sel_ok && last_ok) begin
              ptr   <= bus.sel_in;
              last  <= bus.last_in;
              state <= SCAN;
            end else begin
              err_q <= 1'b1;
            end
          end else if (bus.rd) begin
            if (sel_ok) begin
              res_q   <= mux_word;
              cur_q   <= bus.sel_in;
              valid_q <= 1'b1;
            end else begin
              res_q <= '0;
              cur_q <= '0;
              err_q <= 1'b1;
            end
          end
        end
        SCAN: begin
          // Abort wins over advance; an aborted scan leaves RES untouched.
          if (bus.abort) begin
            state <= IDLE;
          end else if (bus.adv) begin
            res_q   <= mux_word;
            cur_q   <= ptr;
            valid_q <= 1'b1;
            if (ptr == last) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              ptr <= SEL_W'(next_index(32'(ptr), NUM));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.RES     = res_q;
  assign bus.cur_sel = cur_q;
  assign bus.valid   = valid_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule
